// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mm_pkg
// Description : Shared types and controller state codes for the matrix-multiply
//               job scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package mm_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AS   = 3'd1,
        SA   = 3'd2,
        SB   = 3'd3,
        BS   = 3'd4
    } mode_e;

    localparam logic [3:0] ST_FREE        = 4'd0;
    localparam logic [3:0] ST_AS_WAITHASH = 4'd3;
    localparam logic [3:0] ST_SA_WAITHASH = 4'd7;
    localparam logic [3:0] ST_DEBUG       = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_START   = 3'd2,
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4,
        S_HASH    = 3'd5,
        S_DONE    = 3'd6
    } sched_st_e;

    function automatic logic mode_legal(input logic [2:0] mode);
        return (mode >= 3'd1) && (mode <= 3'd4);
    endfunction

    // Controller parks in one of these codes waiting for HASH_ready.
    function automatic logic is_parked(input logic [3:0] cs);
        return (cs == ST_AS_WAITHASH) || (cs == ST_SA_WAITHASH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mm_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mm_cmd_fifo
// Description : Show-ahead synchronous FIFO holding queued scheduler commands.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_cmd_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int              c_ADDR_W = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0] c_DEPTH = (c_ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic                w_push;
    logic                w_pop;

    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign full     = (r_count == c_DEPTH);
    assign empty    = (r_count == '0);
    assign pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ADDR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_ADDR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mm_job_sched.sv
`default_nettype none
// ============================================================================
// Module      : mm_job_sched
// Description : Queues host matrix jobs and sequences them through the
//               multiply controller and the HASH generator handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_job_sched
    import mm_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int BLK_W      = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [BLK_W-1:0] cmd_blocks,
    output logic [2:0]       mem_mode,
    output logic             calc_init,
    output logic             HASH_ready,
    input  logic [3:0]       core_state,
    output logic             hash_req,
    input  logic             hash_ack,
    output logic             job_done,
    output logic             job_err,
    output logic             busy,
    output logic [BLK_W-1:0] blocks_done
);
    localparam int c_ENTRY_W = 3 + BLK_W;

    sched_st_e          r_state;
    logic [2:0]         r_mode;
    logic [BLK_W-1:0]   r_target;
    logic [3:0]         r_core_state_q;

    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic [c_ENTRY_W-1:0] w_head;
    logic [2:0]         w_head_mode;
    logic [BLK_W-1:0]   w_head_blocks;
    logic               w_block_event;
    logic               w_ack;
    logic [BLK_W-1:0]   w_blocks_inc;

    assign cmd_ready     = !w_full;
    assign w_pop         = (r_state == S_IDLE) && !w_empty;
    assign w_head_mode   = w_head[c_ENTRY_W-1 -: 3];
    assign w_head_blocks = w_head[BLK_W-1:0];
    assign w_ack         = hash_req && hash_ack;
    assign w_block_event = is_parked(core_state) && !is_parked(r_core_state_q);
    assign w_blocks_inc  = (blocks_done == '1) ? blocks_done : blocks_done + BLK_W'(1);

    mm_cmd_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid && cmd_ready),
        .push_data ({cmd_mode, cmd_blocks}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_mode         <= '0;
            r_target       <= '0;
            r_core_state_q <= '0;
            mem_mode       <= '0;
            calc_init      <= 1'b0;
            HASH_ready     <= 1'b0;
            hash_req       <= 1'b0;
            job_done       <= 1'b0;
            job_err        <= 1'b0;
            busy           <= 1'b0;
            blocks_done    <= '0;
        end else begin
            calc_init      <= 1'b0;
            HASH_ready     <= 1'b0;
            job_done       <= 1'b0;
            job_err        <= 1'b0;
            r_core_state_q <= core_state;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_mode      <= w_head_mode;
                        r_target    <= w_head_blocks;
                        blocks_done <= '0;
                        if (!mode_legal(w_head_mode)) begin
                            job_err <= 1'b1;
                        end else if (w_head_blocks == '0) begin
                            job_done <= 1'b1;
                        end else begin
                            hash_req <= 1'b1;
                            busy     <= 1'b1;
                            r_state  <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (w_ack) begin
                        hash_req <= 1'b0;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    mem_mode  <= r_mode;
                    calc_init <= 1'b1;
                    r_state   <= S_RELEASE;
                end
                S_RELEASE: begin
                    // A controller left parked by the previous job needs a kick.
                    HASH_ready <= is_parked(core_state);
                    r_state    <= S_RUN;
                end
                S_RUN: begin
                    if (w_block_event) begin
                        blocks_done <= w_blocks_inc;
                        if (w_blocks_inc == r_target) begin
                            job_done <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            hash_req <= 1'b1;
                            r_state  <= S_HASH;
                        end
                    end
                end
                S_HASH: begin
                    if (w_ack) begin
                        hash_req   <= 1'b0;
                        HASH_ready <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    hash_req <= 1'b0;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mm_job_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mm_job_sched
// Description : Directed self-checking bench for mm_job_sched with a small
//               HASH responder and controller model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mm_job_sched;
    localparam int BLK_W = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_mode;
    logic [BLK_W-1:0] cmd_blocks;
    logic [2:0]       mem_mode;
    logic             calc_init;
    logic             HASH_ready;
    logic [3:0]       core_state;
    logic             hash_req;
    logic             hash_ack;
    logic             job_done;
    logic             job_err;
    logic             busy;
    logic [BLK_W-1:0] blocks_done;

    mm_job_sched #(.FIFO_DEPTH(4), .BLK_W(BLK_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_mode    (cmd_mode),
        .cmd_blocks  (cmd_blocks),
        .mem_mode    (mem_mode),
        .calc_init   (calc_init),
        .HASH_ready  (HASH_ready),
        .core_state  (core_state),
        .hash_req    (hash_req),
        .hash_ack    (hash_ack),
        .job_done    (job_done),
        .job_err     (job_err),
        .busy        (busy),
        .blocks_done (blocks_done)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int n_calc, n_hrdy, n_done, n_err, n_req, n_ack, n_rel, n_hlat, max_busy;
    int t_calc, t_ack, t_done, t_err, t_req;
    int req_age, acks_left, ctrl_cnt;
    bit ctrl_model;
    logic hreq_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_cnt();
        n_calc = 0; n_hrdy = 0; n_done = 0; n_err = 0; n_req = 0; n_ack = 0;
        n_rel = 0; n_hlat = 0; max_busy = 0;
        t_calc = -100; t_ack = -100; t_done = -100; t_err = -100; t_req = -100;
    endtask

    // One cycle: sample outputs at the falling edge, then update the models.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (busy) max_busy = 1;
        if (calc_init) begin n_calc++; t_calc = cyc; end
        if (job_done)  begin n_done++; t_done = cyc; end
        if (job_err)   begin n_err++;  t_err  = cyc; end
        if (HASH_ready) begin
            n_hrdy++;
            if (cyc - t_calc == 1) n_rel++;
            if (cyc - t_ack == 1 && !hash_req) n_hlat++;
        end
        hash_ack = 1'b0;
        if (hash_req) begin
            if (!hreq_prev) begin n_req++; req_age = 0; t_req = cyc; end
            else req_age++;
            if (req_age >= 2 && acks_left != 0) begin
                hash_ack = 1'b1;
                n_ack++;
                t_ack = cyc;
                if (acks_left > 0) acks_left--;
            end
        end
        hreq_prev = hash_req;
        if (ctrl_model) begin
            if (calc_init && core_state == 4'd0) begin
                core_state = 4'd1; ctrl_cnt = 20;
            end else if (HASH_ready && core_state == 4'd3) begin
                core_state = 4'd2; ctrl_cnt = 20;
            end else if (ctrl_cnt > 0) begin
                ctrl_cnt--;
                if (ctrl_cnt == 0) core_state = 4'd3;
            end
        end
    endtask

    task automatic push(input logic [2:0] mode, input logic [BLK_W-1:0] blks, output logic acc);
        cmd_valid  = 1'b1;
        cmd_mode   = mode;
        cmd_blocks = blks;
        acc        = cmd_ready;
        tick();
        cmd_valid  = 1'b0;
    endtask

    logic acc;
    int   td;
    logic exp_acc [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_blocks = '0;
        core_state = 4'd0; hash_ack = 1'b0; hreq_prev = 1'b0;
        req_age = 0; acks_left = 0; ctrl_cnt = 0; ctrl_model = 1'b0;
        clr_cnt();
        tick(); tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_pulses", {calc_init, HASH_ready, job_done, job_err}, 0);
        chk("rst_hash_req", hash_req, 0);
        chk("rst_busy_mode_blk", {busy, mem_mode, blocks_done}, 0);
        rst_n = 1'b1;
        tick();

        // Single AS job of three blocks
        ctrl_model = 1'b1; acks_left = -1; clr_cnt();
        push(3'd1, 10'd3, acc);
        chk("t1_accept", acc, 1);
        for (int i = 0; i < 400 && n_done < 1; i++) tick();
        chk("t1_done", n_done, 1);
        tick();
        chk("t1_calc", n_calc, 1);
        chk("t1_mem_mode", mem_mode, 1);
        chk("t1_req", n_req, 3);
        chk("t1_ack", n_ack, 3);
        chk("t1_hrdy", n_hrdy, 2);
        chk("t1_hrdy_lat", n_hlat, 2);
        chk("t1_blocks", blocks_done, 3);
        chk("t1_busy_end", busy, 0);

        // Back-to-back jobs against a parked controller
        clr_cnt();
        push(3'd1, 10'd1, acc);
        push(3'd2, 10'd1, acc);
        for (int i = 0; i < 300 && n_done < 1; i++) tick();
        chk("t2_done1", n_done, 1);
        td = t_done;
        for (int i = 0; i < 20 && n_req < 2; i++) tick();
        chk("t2_b2b_gap", t_req - td, 2);
        for (int i = 0; i < 300 && n_done < 2; i++) tick();
        chk("t2_done2", n_done, 2);
        chk("t2_calc", n_calc, 2);
        chk("t2_release_hrdy", n_rel, 2);
        chk("t2_mem_mode", mem_mode, 2);
        chk("t2_blocks", blocks_done, 1);

        // Illegal mode then zero-block job
        tick(); clr_cnt();
        push(3'd6, 10'd5, acc);
        push(3'd2, 10'd0, acc);
        for (int i = 0; i < 6; i++) tick();
        chk("t3_err", n_err, 1);
        chk("t3_done", n_done, 1);
        chk("t3_order", (t_err < t_done), 1);
        chk("t3_no_calc", n_calc, 0);
        chk("t3_no_req", n_req, 0);
        chk("t3_no_busy", max_busy, 0);

        // Queue full while the FSM waits in S_FETCH
        clr_cnt(); acks_left = 0;
        push(3'd1, 10'd2, acc);
        for (int i = 0; i < 10 && !hash_req; i++) tick();
        chk("t4_fetch", hash_req, 1);
        for (int k = 0; k < 5; k++) begin
            push(3'd2, 10'd1, acc);
            chk($sformatf("t4_acc%0d", k), acc, exp_acc[k]);
        end
        tick(); tick();
        chk("t4_full", cmd_ready, 0);
        acks_left = 1;
        for (int i = 0; i < 200 && !(blocks_done == 10'd1 && hash_req); i++) tick();
        chk("t4_in_hash", {blocks_done == 10'd1, hash_req}, 2'b11);
        chk("t4_still_full", cmd_ready, 0);

        // Asynchronous reset in S_HASH
        rst_n = 1'b0;
        #1;
        chk("t5_hash_req", hash_req, 0);
        chk("t5_busy", busy, 0);
        chk("t5_blocks", blocks_done, 0);
        chk("t5_fifo_empty", cmd_ready, 1);
        ctrl_model = 1'b0; core_state = 4'd0; ctrl_cnt = 0;
        tick(); tick();
        rst_n = 1'b1;
        clr_cnt();
        for (int i = 0; i < 5; i++) tick();
        chk("t5_no_job", {max_busy[0], n_req[0]}, 0);

        // Spurious ack in idle and core_state toggling in S_FETCH
        hash_ack = 1'b1;
        tick(); tick();
        chk("t6_idle_ack", busy, 0);
        push(3'd3, 10'd1, acc);
        tick();
        for (int i = 0; i < 6; i++) begin
            core_state = (i % 2 == 0) ? 4'd3 : 4'd2;
            tick();
        end
        chk("t6_fetch_hold", {busy, hash_req}, 2'b11);
        chk("t6_no_count", blocks_done, 0);
        chk("t6_no_calc", n_calc, 0);
        core_state = 4'd0; ctrl_model = 1'b1; acks_left = -1;
        for (int i = 0; i < 200 && n_done < 1; i++) tick();
        chk("t6_done", n_done, 1);
        chk("t6_mem_mode", mem_mode, 3);
        chk("t6_blocks", blocks_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
